mod16skip_chk: RTL
==================

MOD16SKIP_CHK -- requirements
Module: mod16skip_chk

Interface
REQ-001 Parameter LOCK_N, default 2, number of consecutive correct transitions needed to declare lock (legal range 1..7).
REQ-002 Parameter ERRW, default 8, width of the error counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port cnt_in  input  4  counter value under check, sampled when cnt_vld=1.
REQ-006 Port cnt_vld  input  1  qualifies cnt_in; when 0 the block holds all state.
REQ-007 Port clr_err  input  1  synchronous clear of err_cnt.
REQ-008 Port locked  output  1  high while the monitor tracks the sequence.
REQ-009 Port err  output  1  one-cycle pulse on a sequence mismatch while locked.
REQ-010 Port illegal  output  1  one-cycle pulse when a sampled value is 10, 12 or 14.
REQ-011 Port wrap  output  1  one-cycle pulse on an observed 15->0 transition while locked.
REQ-012 Port exp_cnt  output  4  value expected at the next valid sample.
REQ-013 Port err_cnt  output  ERRW  saturating count of err pulses.

Function
REQ-014 Legal set SHALL be {0..9, 11, 13, 15}; successor nxt(v) SHALL be v+1 for v<=8, v+2 for v in {9, 11, 13}, and 0 for v=15 (4-bit, no other wrap).
REQ-015 All outputs SHALL be registered; each response appears one clock after the cnt_vld sampling edge.
REQ-016 FSM states: UNSYNC, LOCKING, LOCKED; locked=1 only in LOCKED.
REQ-017 UNSYNC, valid legal v: load exp_cnt=nxt(v), run=0, go LOCKING; valid illegal v: pulse illegal, stay UNSYNC.
REQ-018 LOCKING, valid v==exp_cnt: run+1, exp_cnt=nxt(v); when run reaches LOCK_N go LOCKED.
REQ-019 LOCKING, valid legal v!=exp_cnt: run=0, exp_cnt=nxt(v), stay LOCKING; no err pulse.
REQ-020 LOCKING, valid illegal v: pulse illegal, go UNSYNC.
REQ-021 LOCKED, valid v==exp_cnt: exp_cnt=nxt(v), stay; pulse wrap if v=0 and the previous sample was 15.
REQ-022 LOCKED, valid v!=exp_cnt: pulse err, increment err_cnt; if v legal go LOCKING with run=0, exp_cnt=nxt(v); if v illegal also pulse illegal and go UNSYNC.
REQ-023 err_cnt SHALL saturate at 2^ERRW-1 and not wrap.
REQ-024 clr_err with no increment sets err_cnt=0; clr_err coincident with an increment sets err_cnt=1.
REQ-025 cnt_vld=0 SHALL hold state, run, and exp_cnt; err, illegal, and wrap are 0 in the following cycle.
REQ-026 Gaps in cnt_vld SHALL NOT count as errors; only valid samples are compared.

Reset
REQ-027 rst=1 SHALL immediately force state=UNSYNC, run=0, exp_cnt=0, err_cnt=0, locked=0, err=0, illegal=0, wrap=0, regardless of clk.
REQ-028 Reset asserted mid-lock SHALL discard the lock; after release, relock requires LOCK_N+1 valid samples again.
REQ-029 First valid sample after reset release SHALL be handled as in UNSYNC.

Verification
REQ-030 Lock: LOCK_N=2, feed 0,1,2 valid back-to-back -> locked=1 one cycle after the sample 2, exp_cnt=3, err_cnt=0.
REQ-031 Full cycle: locked, feed 3..9,11,13,15,0 -> no err, no illegal, wrap pulses once after the 0 sample, exp_cnt=1.
REQ-032 Mismatch: locked with exp_cnt=9, feed 11 -> err pulse, err_cnt=1, locked=0, exp_cnt=13; feed 13,15 -> locked=1 again.
REQ-033 Illegal value: locked with exp_cnt=10... invalid by construction, so locked after 9, feed 10 -> err and illegal pulse together, state UNSYNC, err_cnt+1.
REQ-034 Gaps and saturation: ERRW=2, toggle cnt_vld with matching samples -> no err; force 5 mismatches -> err_cnt stays 3; clr_err together with a mismatch -> err_cnt=1.
REQ-035 Async reset: locked at exp_cnt=6, assert rst between clock edges -> locked=0 and err_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/mod16skip_chk.sv
// mod16skip_chk
//   Monitors a 4-bit counter that follows the skip sequence
//   0,1,..,9,11,13,15,0,... and reports whether it stays in step.
//   After LOCK_N+1 consecutive in-order valid samples the monitor declares
//   lock; from then on any out-of-order sample is flagged as an error.
//
// Parameters
//   LOCK_N  consecutive correct transitions needed for lock (1..7)
//   ERRW    width of the saturating error counter
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   cnt_in   counter value under check
//   cnt_vld  qualifies cnt_in; when low all state is held
//   clr_err  synchronous clear of err_cnt
//   locked   high while the monitor tracks the sequence
//   err      one-cycle pulse on a mismatch while locked
//   illegal  one-cycle pulse when a sampled value is 10, 12 or 14
//   wrap     one-cycle pulse on an observed 15->0 step while locked
//   exp_cnt  value expected at the next valid sample
//   err_cnt  saturating count of err pulses
module mod16skip_chk #(
  parameter int LOCK_N = 2,
  parameter int ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      cnt_in,
  input  logic            cnt_vld,
  input  logic            clr_err,
  output logic            locked,
  output logic            err,
  output logic            illegal,
  output logic            wrap,
  output logic [3:0]      exp_cnt,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic [1:0] {UNSYNC, LOCKING, LOCKED} state_t;

  localparam logic [2:0]      LOCK_RUN = 3'(LOCK_N);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  state_t          state_q, state_d;
  logic [2:0]      run_q, run_d;
  logic [3:0]      exp_q, exp_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic            illegal_q, illegal_d;
  logic            wrap_q, wrap_d;
  logic            err_inc;

  // Values the counter may legally take: 0..9 and the odd values above 9.
  function automatic logic is_legal(input logic [3:0] v);
    return (v <= 4'd9) || (v == 4'd11) || (v == 4'd13) || (v == 4'd15);
  endfunction

  // Successor in the skip sequence; only meaningful for legal inputs.
  function automatic logic [3:0] nxt(input logic [3:0] v);
    logic [3:0] r;
    if (v <= 4'd8)       r = v + 4'd1;
    else if (v == 4'd15) r = 4'd0;
    else                 r = v + 4'd2;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    exp_d     = exp_q;
    err_d     = 1'b0;
    illegal_d = 1'b0;
    wrap_d    = 1'b0;
    err_inc   = 1'b0;

    if (cnt_vld) begin
      case (state_q)
        UNSYNC: begin
          if (is_legal(cnt_in)) begin
            exp_d   = nxt(cnt_in);
            run_d   = 3'd0;
            state_d = LOCKING;
          end else begin
            illegal_d = 1'b1;
          end
        end

        LOCKING: begin
          if (!is_legal(cnt_in)) begin
            illegal_d = 1'b1;
            run_d     = 3'd0;
            state_d   = UNSYNC;
          end else if (cnt_in == exp_q) begin
            run_d = run_q + 3'd1;
            exp_d = nxt(cnt_in);
            if (run_q + 3'd1 == LOCK_RUN) state_d = LOCKED;
          end else begin
            // Resynchronise on the new value without flagging an error.
            run_d = 3'd0;
            exp_d = nxt(cnt_in);
          end
        end

        LOCKED: begin
          if (cnt_in == exp_q) begin
            exp_d  = nxt(cnt_in);
            // exp_cnt can only be 0 here if the previous valid sample was 15.
            wrap_d = (cnt_in == 4'd0);
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            run_d   = 3'd0;
            if (is_legal(cnt_in)) begin
              exp_d   = nxt(cnt_in);
              state_d = LOCKING;
            end else begin
              illegal_d = 1'b1;
              state_d   = UNSYNC;
            end
          end
        end

        default: begin
          state_d = UNSYNC;
          run_d   = 3'd0;
        end
      endcase
    end

    // A clear that coincides with a new error leaves exactly that error counted.
    if (clr_err && err_inc)   err_cnt_d = {{(ERRW-1){1'b0}}, 1'b1};
    else if (clr_err)         err_cnt_d = '0;
    else if (err_inc && err_cnt_q != ERR_MAX)
                              err_cnt_d = err_cnt_q + 1'b1;
    else                      err_cnt_d = err_cnt_q;

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UNSYNC;
      run_q     <= 3'd0;
      exp_q     <= 4'd0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      exp_q     <= exp_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
      wrap_q    <= wrap_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign illegal = illegal_q;
  assign wrap    = wrap_q;
  assign exp_cnt = exp_q;
  assign err_cnt = err_cnt_q;

endmodule
